// File: rtl/zbt_arbiter.sv
// Round-robin arbiter sharing one pipelined ZBT SRAM between a writer and a reader.
// Tracks each granted command through the RAM pipeline to time write-data drive and read-data capture.
module zbt_arbiter #(
    parameter int unsigned ADDR_W       = 19,
    parameter int unsigned DATA_W       = 36,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              locked,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we_b,
    output logic              ram_cen_b,
    output logic [DATA_W-1:0] ram_data_out,
    output logic              ram_data_oe,
    input  logic [DATA_W-1:0] ram_data_in
);

    typedef enum logic {WAIT_LOCK, RUN} state_t;
    typedef enum logic {GRANT_WRITE, GRANT_READ} grant_t;

    state_t                               state_q, state_d;
    grant_t                               last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]                    ram_addr_q, ram_addr_d;
    logic                                 ram_we_b_q, ram_we_b_d;
    logic                                 ram_cen_b_q, ram_cen_b_d;
    logic [READ_LATENCY:0]                pipe_v_q, pipe_v_d;
    logic [READ_LATENCY:0]                pipe_w_q, pipe_w_d;
    logic [READ_LATENCY:0][DATA_W-1:0]    pipe_data_q, pipe_data_d;
    logic [DATA_W-1:0]                    rd_data_q, rd_data_d;
    logic                                 rd_valid_q, rd_valid_d;
    logic                                 grant_en, wr_grant, rd_grant;

    always_comb begin
        // Acks are gated by reset too, so a requester never sees an ack that reset then discards.
        grant_en = (state_q == RUN) && locked && !reset;
        wr_grant = grant_en && wr_req && (!rd_req || (last_grant_q == GRANT_READ));
        rd_grant = grant_en && rd_req && !wr_grant;

        state_d = state_q;
        case (state_q)
            WAIT_LOCK: if (locked)  state_d = RUN;
            RUN:       if (!locked) state_d = WAIT_LOCK;
            default:                state_d = WAIT_LOCK;
        endcase

        last_grant_d = last_grant_q;
        if (wr_grant)      last_grant_d = GRANT_WRITE;
        else if (rd_grant) last_grant_d = GRANT_READ;

        ram_addr_d  = ram_addr_q;
        if (wr_grant)      ram_addr_d = wr_addr;
        else if (rd_grant) ram_addr_d = rd_addr;
        ram_cen_b_d = !(wr_grant || rd_grant);
        ram_we_b_d  = !wr_grant;

        pipe_v_d       = pipe_v_q;
        pipe_w_d       = pipe_w_q;
        pipe_data_d    = pipe_data_q;
        pipe_v_d[0]    = wr_grant || rd_grant;
        pipe_w_d[0]    = wr_grant;
        pipe_data_d[0] = wr_grant ? wr_data : '0;
        for (int unsigned i = 1; i <= READ_LATENCY; i++) begin
            pipe_v_d[i]    = pipe_v_q[i-1];
            pipe_w_d[i]    = pipe_w_q[i-1];
            pipe_data_d[i] = pipe_data_q[i-1];
        end

        // The last stage is the RAM's data cycle: reads are captured at its end.
        rd_valid_d = pipe_v_q[READ_LATENCY] && !pipe_w_q[READ_LATENCY];
        rd_data_d  = rd_valid_d ? ram_data_in : rd_data_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= WAIT_LOCK;
            last_grant_q <= GRANT_WRITE;
            ram_addr_q   <= '0;
            ram_we_b_q   <= 1'b1;
            ram_cen_b_q  <= 1'b1;
            pipe_v_q     <= '0;
            pipe_w_q     <= '0;
            pipe_data_q  <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            ram_addr_q   <= ram_addr_d;
            ram_we_b_q   <= ram_we_b_d;
            ram_cen_b_q  <= ram_cen_b_d;
            pipe_v_q     <= pipe_v_d;
            pipe_w_q     <= pipe_w_d;
            pipe_data_q  <= pipe_data_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    assign wr_ack       = wr_grant;
    assign rd_ack       = rd_grant;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign ram_addr     = ram_addr_q;
    assign ram_we_b     = ram_we_b_q;
    assign ram_cen_b    = ram_cen_b_q;
    assign ram_data_oe  = pipe_v_q[READ_LATENCY] && pipe_w_q[READ_LATENCY];
    assign ram_data_out = pipe_data_q[READ_LATENCY];

endmodule

// File: tb/tb_zbt_arbiter.sv
// Directed bench for zbt_arbiter: scoreboard queues filled at grant time, drained by a pin monitor,
// with a behavioural ZBT model answering reads two edges after the address is sampled.
module tb_zbt_arbiter;

    localparam int AW = 19;
    localparam int DW = 36;
    localparam int RL = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          locked = 1'b0;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ack;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_ack;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [AW-1:0] ram_addr;
    logic          ram_we_b;
    logic          ram_cen_b;
    logic [DW-1:0] ram_data_out;
    logic          ram_data_oe;
    logic [DW-1:0] ram_data_in = '0;

    zbt_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)) dut (
        .clock(clock), .reset(reset), .locked(locked),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .ram_addr(ram_addr), .ram_we_b(ram_we_b), .ram_cen_b(ram_cen_b),
        .ram_data_out(ram_data_out), .ram_data_oe(ram_data_oe), .ram_data_in(ram_data_in)
    );

    always #10 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { int cyc; logic [AW-1:0] addr; logic we_b; } cmd_t;
    typedef struct { int cyc; logic [DW-1:0] d; } dat_t;
    cmd_t cmd_q[$];
    dat_t wdata_q[$];
    dat_t rdata_q[$];
    logic [DW-1:0] shadow [logic [AW-1:0]];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // ZBT bus model: address sampled at an edge, data on the bus after two more edges.
    logic [DW-1:0] mem [logic [AW-1:0]];
    logic          m1_v = 1'b0, m1_we_b = 1'b1, m2_v = 1'b0, m2_we_b = 1'b1;
    logic [AW-1:0] m1_a = '0, m2_a = '0;
    always @(posedge clock) begin
        if (m2_v && !m2_we_b) mem[m2_a] = ram_data_oe ? ram_data_out : '1;
        if (m1_v && m1_we_b) ram_data_in <= mem.exists(m1_a) ? mem[m1_a] : '0;
        else                 ram_data_in <= '0;
        m2_v <= m1_v; m2_we_b <= m1_we_b; m2_a <= m1_a;
        m1_v <= (ram_cen_b === 1'b0); m1_we_b <= ram_we_b; m1_a <= ram_addr;
    end

    // Monitor: every pin event must match the oldest expectation, including its cycle.
    always @(negedge clock) begin
        cmd_t c;
        dat_t d;
        if (ram_cen_b === 1'b0) begin
            n_vec++;
            if (cmd_q.size() == 0) begin
                n_err++;
                $display("FAIL cmd: unexpected command addr %h we_b %b (cycle %0d)", ram_addr, ram_we_b, cyc);
            end else begin
                c = cmd_q.pop_front();
                if (c.cyc != cyc || c.addr !== ram_addr || c.we_b !== ram_we_b) begin
                    n_err++;
                    $display("FAIL cmd: got cyc %0d addr %h we_b %b, expected cyc %0d addr %h we_b %b",
                             cyc, ram_addr, ram_we_b, c.cyc, c.addr, c.we_b);
                end
            end
        end
        if (ram_data_oe !== 1'b0) begin
            n_vec++;
            if (wdata_q.size() == 0) begin
                n_err++;
                $display("FAIL wdata: unexpected oe=%b data %h (cycle %0d)", ram_data_oe, ram_data_out, cyc);
            end else begin
                d = wdata_q.pop_front();
                if (d.cyc != cyc || d.d !== ram_data_out) begin
                    n_err++;
                    $display("FAIL wdata: got cyc %0d data %h, expected cyc %0d data %h",
                             cyc, ram_data_out, d.cyc, d.d);
                end
            end
        end
        if (rd_valid !== 1'b0) begin
            n_vec++;
            if (rdata_q.size() == 0) begin
                n_err++;
                $display("FAIL rdata: unexpected rd_valid=%b data %h (cycle %0d)", rd_valid, rd_data, cyc);
            end else begin
                d = rdata_q.pop_front();
                if (d.cyc != cyc || d.d !== rd_data) begin
                    n_err++;
                    $display("FAIL rdata: got cyc %0d data %h, expected cyc %0d data %h",
                             cyc, rd_data, d.cyc, d.d);
                end
            end
        end
    end

    // One cycle: check acks against the expected grant and enqueue what that grant must produce.
    task automatic tick(input logic ew, input logic er, input logic quiet);
        cmd_t c;
        dat_t d;
        @(negedge clock);
        chk("wr_ack", {63'd0, wr_ack}, {63'd0, ew});
        chk("rd_ack", {63'd0, rd_ack}, {63'd0, er});
        if (quiet) begin
            chk("quiet_rd_valid", {63'd0, rd_valid}, 64'd0);
            chk("quiet_oe", {63'd0, ram_data_oe}, 64'd0);
        end
        if (ew) begin
            c.cyc = cyc + 1; c.addr = wr_addr; c.we_b = 1'b0; cmd_q.push_back(c);
            d.cyc = cyc + 1 + RL; d.d = wr_data; wdata_q.push_back(d);
            shadow[wr_addr] = wr_data;
        end
        if (er) begin
            c.cyc = cyc + 1; c.addr = rd_addr; c.we_b = 1'b1; cmd_q.push_back(c);
            d.cyc = cyc + 2 + RL; d.d = shadow.exists(rd_addr) ? shadow[rd_addr] : '0;
            rdata_q.push_back(d);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset held, lock low, writer requesting
        wr_req = 1'b1; wr_addr = 19'h00010; wr_data = 36'h123456789;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            chk("rst_cen_b", {63'd0, ram_cen_b}, 64'd1);
            chk("rst_we_b", {63'd0, ram_we_b}, 64'd1);
        end
        chk("rst_rd_data", {28'd0, rd_data}, 64'd0);
        chk("rst_ram_addr", {45'd0, ram_addr}, 64'd0);
        chk("rst_data_out", {28'd0, ram_data_out}, 64'd0);
        reset = 1'b0;
        tick(1'b0, 1'b0, 1'b1);

        // 2: lock, single write (one WAIT_LOCK cycle before RUN)
        locked = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        wr_req = 1'b0;
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0);

        // 3: single read of the word just written
        rd_req = 1'b1; rd_addr = 19'h00010;
        tick(1'b0, 1'b1, 1'b0);
        rd_req = 1'b0;
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0);
        chk("t3_rd_data", {28'd0, rd_data}, {28'd0, 36'h123456789});

        // 4: both held after reset, alternating R,W with read-after-write back to back
        reset = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
        wr_req = 1'b1; wr_addr = 19'h00020; wr_data = 36'hA00000000;
        rd_req = 1'b1; rd_addr = 19'h00010;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                tick(1'b0, 1'b1, 1'b0);
                rd_addr = 19'h00020 + 19'(i / 2);
            end else begin
                tick(1'b1, 1'b0, 1'b0);
                wr_addr = wr_addr + 19'd1;
                wr_data = wr_data + 36'd1;
            end
        end
        wr_req = 1'b0; rd_req = 1'b0;
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 1'b0);

        // 5: lock drops right after a write grant
        wr_req = 1'b1; wr_addr = 19'h00030; wr_data = 36'h0F0F0F0F0;
        tick(1'b1, 1'b0, 1'b0);
        locked = 1'b0; wr_req = 1'b0; rd_req = 1'b1; rd_addr = 19'h00030;
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            chk("t5_idle_cen_b", {63'd0, ram_cen_b}, 64'd1);
        end
        locked = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        rd_req = 1'b0;
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0);

        // 6: reset one cycle after a read grant discards it; reader wins the next tie
        rd_req = 1'b1; rd_addr = 19'h00010;
        tick(1'b0, 1'b1, 1'b0);
        reset = 1'b1; rd_req = 1'b0;
        wdata_q.delete();
        rdata_q.delete();
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        wr_req = 1'b1; wr_addr = 19'h00040; wr_data = 36'h555555555;
        rd_req = 1'b1; rd_addr = 19'h00030;
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        wr_req = 1'b0; rd_req = 1'b0;
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 1'b0);

        chk("end_cmd_q_empty", 64'(cmd_q.size()), 64'd0);
        chk("end_wdata_q_empty", 64'(wdata_q.size()), 64'd0);
        chk("end_rdata_q_empty", 64'(rdata_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
